// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - front-end stall/flush arbitration with syscall drain sequencing
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REDIRECT,
   input  logic             SYSCALL_ID,
   input  logic             LOAD_USE,
   input  logic             IF_MISS,
   input  logic             SYSCALL_DONE,
   output logic             STALL_IF,
   output logic             STALL_IFID,
   output logic             FLUSH_IFID,
   output logic             FLUSH_IDEX,
   output logic             SYSCALL_REQ,
   output logic [1:0]       STATE,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_RESUME = 2'd3;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [3:0] drain_cnt;
   logic [3:0] drain_cnt_nxt;
   logic       redirect_take;

   assign STATE = state;

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      redirect_take = 1'b0;
      STALL_IF      = 1'b0;
      STALL_IFID    = 1'b0;
      FLUSH_IFID    = 1'b0;
      FLUSH_IDEX    = 1'b0;
      SYSCALL_REQ   = 1'b0;
      if (!RESET) begin
         // Hold both pipeline registers empty while reset is asserted.
         FLUSH_IFID = 1'b1;
         FLUSH_IDEX = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (REDIRECT) begin
                  FLUSH_IFID    = 1'b1;
                  FLUSH_IDEX    = 1'b1;
                  STALL_IF      = IF_MISS;
                  redirect_take = 1'b1;
               end else if (SYSCALL_ID) begin
                  STALL_IF      = 1'b1;
                  STALL_IFID    = 1'b1;
                  FLUSH_IDEX    = 1'b1;
                  drain_cnt_nxt = DRAIN_LOAD;
                  state_nxt     = ST_DRAIN;
               end else if (LOAD_USE) begin
                  STALL_IF   = 1'b1;
                  STALL_IFID = 1'b1;
                  FLUSH_IDEX = 1'b1;
               end else if (IF_MISS) begin
                  STALL_IF   = 1'b1;
                  FLUSH_IFID = 1'b1;
               end
            end
            ST_DRAIN: begin
               if (REDIRECT) begin
                  // An older branch went the other way: the syscall is wrong-path.
                  FLUSH_IFID    = 1'b1;
                  FLUSH_IDEX    = 1'b1;
                  STALL_IF      = IF_MISS;
                  redirect_take = 1'b1;
                  drain_cnt_nxt = 4'd0;
                  state_nxt     = ST_RUN;
               end else begin
                  STALL_IF   = 1'b1;
                  STALL_IFID = 1'b1;
                  FLUSH_IDEX = 1'b1;
                  if (drain_cnt == 4'd0) begin
                     state_nxt = ST_WAIT;
                  end else begin
                     drain_cnt_nxt = drain_cnt - 4'd1;
                  end
               end
            end
            ST_WAIT: begin
               STALL_IF    = 1'b1;
               STALL_IFID  = 1'b1;
               FLUSH_IDEX  = 1'b1;
               SYSCALL_REQ = 1'b1;
               if (SYSCALL_DONE) begin
                  state_nxt = ST_RESUME;
               end
            end
            default: begin
               FLUSH_IFID = 1'b1;
               STALL_IF   = IF_MISS;
               state_nxt  = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= ST_RUN;
         drain_cnt <= 4'd0;
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (STALL_IFID && (STALL_CNT != {CNT_W{1'b1}})) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
         end
         if (redirect_take && (FLUSH_CNT != {CNT_W{1'b1}})) begin
            FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Front-end pipeline controller. It generates STALL/FLUSH for the IF stage, the IF/ID pipeline register and the ID/EX pipeline register.
- Arbitrates between these hazard sources:
  - branch redirect from EX
  - syscall decoded in ID
  - load-use dependency detected in ID
  - instruction-fetch miss
- Sequences syscalls with a drain/wait/resume FSM and keeps saturating performance counters.

Parameters:
- DRAIN_CYCLES, 3, cycles allowed for instructions older than the syscall to retire before the syscall is serviced (legal range 1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  input  1  clock
- RESET  input  1  reset, asynchronous, active-low
- REDIRECT  input  1  EX resolved a taken or mispredicted branch this cycle
- SYSCALL_ID  input  1  instruction currently in ID is a syscall
- LOAD_USE  input  1  ID instruction sources the destination of the load in EX
- IF_MISS  input  1  fetch has no valid instruction this cycle
- SYSCALL_DONE  input  1  host has serviced the syscall (single-cycle pulse)
- STALL_IF  output  1  hold PC / fetch
- STALL_IFID  output  1  STALL to the IF/ID register
- FLUSH_IFID  output  1  FLUSH to the IF/ID register (zeroes it next edge)
- FLUSH_IDEX  output  1  FLUSH to the ID/EX register (inject bubble)
- SYSCALL_REQ  output  1  level request to the host; pipeline is drained
- STATE  output  2  FSM state: 0 RUN, 1 DRAIN, 2 WAIT, 3 RESUME
- STALL_CNT  output  CNT_W  cycles with STALL_IFID=1
- FLUSH_CNT  output  CNT_W  number of REDIRECT flushes taken

Behaviour:
- State, drain counter, STALL_CNT and FLUSH_CNT are registered. STALL_*, FLUSH_* and SYSCALL_REQ are combinational from state and current inputs; they are valid in the same cycle as the hazard.
- RESET low, asynchronous and at any time, including mid-syscall:
  - STATE=RUN, drain counter=0, STALL_CNT=0, FLUSH_CNT=0.
  - Combinational outputs: STALL_IF=0, STALL_IFID=0, SYSCALL_REQ=0, FLUSH_IFID=1, FLUSH_IDEX=1.
- In RUN, the first matching rule applies:
  1. REDIRECT: FLUSH_IFID=1, FLUSH_IDEX=1, STALL_IF=IF_MISS, STALL_IFID=0. FLUSH_CNT+1. SYSCALL_ID and LOAD_USE are ignored because the ID instruction is wrong-path.
  2. SYSCALL_ID: STALL_IF=1, STALL_IFID=1, FLUSH_IDEX=1. Load drain counter with DRAIN_CYCLES-1. Go to DRAIN.
  3. LOAD_USE: STALL_IF=1, STALL_IFID=1, FLUSH_IDEX=1. Latency is exactly 1 bubble per asserted cycle.
  4. IF_MISS: STALL_IF=1, FLUSH_IFID=1 (bubble into ID), STALL_IFID=0.
  5. None: all STALL/FLUSH outputs 0.
- DRAIN: STALL_IF=1, STALL_IFID=1, FLUSH_IDEX=1.
  - REDIRECT (from an older instruction) aborts: FLUSH_IFID=1, FLUSH_IDEX=1, FLUSH_CNT+1, go to RUN. The syscall is discarded.
  - Otherwise, if the counter is 0, go to WAIT; else decrement.
  - DRAIN therefore lasts DRAIN_CYCLES cycles.
- WAIT: STALL_IF=1, STALL_IFID=1, FLUSH_IDEX=1, SYSCALL_REQ=1.
  - REDIRECT, LOAD_USE and IF_MISS are ignored (no older instructions remain in flight).
  - SYSCALL_DONE: go to RESUME next edge.
- RESUME (exactly one cycle): FLUSH_IFID=1 (retires the serviced syscall from ID), STALL_IF=IF_MISS, FLUSH_IDEX=0, STALL_IFID=0. Then go to RUN.
- SYSCALL_DONE outside WAIT is ignored.
- FLUSH dominates STALL at the IF/ID register. The controller never drives FLUSH_IFID=1 together with STALL_IFID=1.
- STALL_CNT increments on every edge where STALL_IFID=1. FLUSH_CNT increments only for REDIRECT-caused flushes. Both counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset: assert RESET=0 mid-WAIT → same cycle STATE=0, SYSCALL_REQ=0, FLUSH_IFID=1, FLUSH_IDEX=1; counters read 0 after release.
- Load-use: LOAD_USE=1 for 2 cycles → STALL_IF=STALL_IFID=FLUSH_IDEX=1 for exactly those 2 cycles; STALL_CNT=2.
- Redirect priority: REDIRECT=1, SYSCALL_ID=1, LOAD_USE=1 together in RUN → FLUSH_IFID=1, FLUSH_IDEX=1, STALL_IFID=0, STATE stays 0, FLUSH_CNT=1.
- Syscall, DRAIN_CYCLES=3:
  - SYSCALL_ID at cycle 0 → STATE=1 for cycles 1-3, STATE=2 from cycle 4 with SYSCALL_REQ=1.
  - SYSCALL_DONE at cycle 7 → STATE=3 at cycle 8 with FLUSH_IFID=1, STATE=0 at cycle 9.
  - STALL_CNT=8.
- Drain abort: REDIRECT in the 2nd DRAIN cycle → STATE=0 next cycle, both flushes asserted, SYSCALL_REQ never 1.
- Saturation: CNT_W=4, LOAD_USE held 20 cycles → STALL_CNT=15 and stays 15.
